spad_accum: RTL and testbench

//  Parametrised 1R1W scratchpad with read-modify-write accumulate, valid/ready handshakes and bulk clear.

---
 rtl/spad_pkg.sv | 46 ++++
 rtl/spad_mem_1r1w.sv | 40 ++++
 rtl/spad_accum.sv | 175 +++++++++++++++++
 tb/tb_spad_accum.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spad_pkg.sv
// spad_pkg: shared types and helpers for the spad_accum scratchpad.
//   spad_state_e : controller states (IDLE, DRAIN, CLEAR)
//   acc_add      : accumulate adder used by the write pipeline.
// Configuration macro: SPAD_ACC_SAT_EN
//   defined     -> accumulate saturates to the signed max/min of the word width
//   not defined -> accumulate wraps modulo 2**width, no clamp logic
package spad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } spad_state_e;

  // Wide enough to hold the sum of any two supported words without overflow.
  localparam int ACC_W = 64;

  // a and b arrive sign-extended from a w-bit word; the caller truncates the
  // return value back to w bits.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b,
    input int                      w
  );
    logic signed [ACC_W-1:0] sum;
`ifdef SPAD_ACC_SAT_EN
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
`endif
    sum = a + b;
`ifdef SPAD_ACC_SAT_EN
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      sum = max_v;
    end else if (sum < min_v) begin
      sum = min_v;
    end
`else
    // Re-sign-extend from w bits: identical to what a w-bit adder would hold.
    sum = (sum <<< (ACC_W - w)) >>> (ACC_W - w);
`endif
    return sum;
  endfunction

endpackage

// File: rtl/spad_mem_1r1w.sv
// spad_mem_1r1w: bare 1R1W storage array for the scratchpad.
//   clk     : clock, all activity on the rising edge
//   rd_en   : read strobe; rd_data updates on the following edge
//   rd_addr : read address
//   rd_data : registered read data (holds last read when rd_en is low)
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
// No reset: contents and rd_data are undefined until written/read.
// A read and a write to the same address on the same edge return the old word.
module spad_mem_1r1w #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [ADDR_BITWIDTH-1:0] rd_addr,
  output logic [DATA_BITWIDTH-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_BITWIDTH-1:0] wr_addr,
  input  logic [DATA_BITWIDTH-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_BITWIDTH;

  logic [DATA_BITWIDTH-1:0] mem_q [DEPTH];
  logic [DATA_BITWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/spad_accum.sv
// spad_accum: partial-sum scratchpad with read-modify-write accumulate,
// valid/ready handshakes and a bulk clear.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   i_rd_valid/o_rd_ready/i_rd_addr: read request handshake
//   o_rd_valid/o_rd_data           : read response, one cycle after accept;
//                                    data is 0 whenever o_rd_valid is 0
//   i_wr_valid/o_wr_ready          : write request handshake
//   i_wr_addr/i_wr_data/i_wr_accum : write address, operand, mode
//                                    (1 = add into stored word, 0 = overwrite)
//   i_clr                          : clear request, honoured only when idle
//   o_busy                         : high while draining / clearing
// Configuration macro: SPAD_ACC_SAT_EN (saturating accumulate, see spad_pkg).
module spad_accum
  import spad_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_rd_valid,
  output logic                     o_rd_ready,
  input  logic [ADDR_BITWIDTH-1:0] i_rd_addr,
  output logic                     o_rd_valid,
  output logic [DATA_BITWIDTH-1:0] o_rd_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [ADDR_BITWIDTH-1:0] i_wr_addr,
  input  logic [DATA_BITWIDTH-1:0] i_wr_data,
  input  logic                     i_wr_accum,
  input  logic                     i_clr,
  output logic                     o_busy
);

  localparam int DEPTH = 2 ** ADDR_BITWIDTH;
  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

  // Control state (reset)
  spad_state_e              state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                     ready_en_q, ready_en_d;
  logic                     vld_p1_q, vld_p1_d;
  logic                     rd_vld_p1_q, rd_vld_p1_d;

  // Write-pipeline data (not reset; qualified by vld_p1_q)
  logic [ADDR_BITWIDTH-1:0]        wr_addr_p1_q, wr_addr_p1_d;
  logic signed [DATA_BITWIDTH-1:0] wr_data_p1_q, wr_data_p1_d;
  logic                            wr_accum_p1_q, wr_accum_p1_d;
  logic                            fwd_p1_q, fwd_p1_d;
  logic signed [DATA_BITWIDTH-1:0] fwd_data_p1_q, fwd_data_p1_d;

  logic                            idle_rdy;
  logic                            wr_acc;
  logic                            rd_acc;
  logic                            acc_rd;
  logic                            clearing;
  logic signed [DATA_BITWIDTH-1:0] mem_rdata;
  logic signed [DATA_BITWIDTH-1:0] old_p1;
  logic signed [DATA_BITWIDTH-1:0] result_p1;

  logic                     mem_rd_en;
  logic [ADDR_BITWIDTH-1:0] mem_rd_addr;
  logic                     mem_wr_en;
  logic [ADDR_BITWIDTH-1:0] mem_wr_addr;
  logic [DATA_BITWIDTH-1:0] mem_wr_data;

  // ready_en_q keeps both readies low while reset is held and for the first
  // edge after release.
  assign idle_rdy   = ready_en_q && (state_q == IDLE);
  assign o_wr_ready = idle_rdy;
  // An accumulate needs the array read port, so a concurrent read must wait.
  assign o_rd_ready = idle_rdy && !(i_wr_valid && i_wr_accum);
  assign o_busy     = (state_q != IDLE);

  assign wr_acc   = i_wr_valid && o_wr_ready;
  assign rd_acc   = i_rd_valid && o_rd_ready;
  assign acc_rd   = wr_acc && i_wr_accum;
  assign clearing = (state_q == CLEAR);

  // ---- S1: accept cycle, issue array read for accumulate or read request ----
  assign mem_rd_en   = acc_rd || rd_acc;
  assign mem_rd_addr = acc_rd ? i_wr_addr : i_rd_addr;

  // ---- S2: combine old word with operand, write array at end of cycle ----
  // The array read issued in S1 misses the S2 write of the previous accept,
  // so a same-address predecessor supplies the old value instead.
  assign old_p1    = fwd_p1_q ? fwd_data_p1_q : mem_rdata;
  assign result_p1 = wr_accum_p1_q
                   ? DATA_BITWIDTH'(acc_add(ACC_W'(old_p1), ACC_W'(wr_data_p1_q), DATA_BITWIDTH))
                   : wr_data_p1_q;

  assign mem_wr_en   = vld_p1_q || clearing;
  assign mem_wr_addr = clearing ? clr_cnt_q : wr_addr_p1_q;
  assign mem_wr_data = clearing ? '0 : result_p1;

  assign o_rd_valid = rd_vld_p1_q;
  assign o_rd_data  = rd_vld_p1_q ? mem_rdata : '0;

  spad_mem_1r1w #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .ADDR_BITWIDTH(ADDR_BITWIDTH)
  ) u_mem (
    .clk     (clk),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rdata),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data)
  );

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ready_en_d    = 1'b1;
    vld_p1_d      = wr_acc;
    rd_vld_p1_d   = rd_acc;
    wr_addr_p1_d  = i_wr_addr;
    wr_data_p1_d  = i_wr_data;
    wr_accum_p1_d = i_wr_accum;
    fwd_p1_d      = vld_p1_q && (wr_addr_p1_q == i_wr_addr);
    fwd_data_p1_d = result_p1;

    unique case (state_q)
      IDLE: begin
        if (i_clr) begin
          state_d = DRAIN;
        end
      end
      // No new writes enter during DRAIN, so any S2 occupant retires this
      // cycle and CLEAR owns the write port from the next one.
      DRAIN: begin
        if (!wr_acc) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_BITWIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      ready_en_q  <= 1'b0;
      vld_p1_q    <= 1'b0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ready_en_q  <= ready_en_d;
      vld_p1_q    <= vld_p1_d;
      rd_vld_p1_q <= rd_vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_p1_q  <= wr_addr_p1_d;
    wr_data_p1_q  <= wr_data_p1_d;
    wr_accum_p1_q <= wr_accum_p1_d;
    fwd_p1_q      <= fwd_p1_d;
    fwd_data_p1_q <= fwd_data_p1_d;
  end

endmodule

// File: tb/tb_spad_accum.sv
// tb_spad_accum: directed + randomized bench for spad_accum.
// Reference model: a "logical" memory updated at write accept (so chained
// accumulates see every increment) and a "committed" memory that reads see,
// which lags the accept by the two-cycle write latency.
module tb_spad_accum;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_rd_valid;
  logic          o_rd_ready;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_wr_accum;
  logic          i_clr;
  logic          o_busy;

  always #5 clk = ~clk;

  spad_accum #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rd_valid (i_rd_valid),
    .o_rd_ready (o_rd_ready),
    .i_rd_addr  (i_rd_addr),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_wr_accum (i_wr_accum),
    .i_clr      (i_clr),
    .o_busy     (o_busy)
  );

  typedef struct {
    int          addr;
    logic [DW-1:0] val;
    int          t;
  } pend_t;

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            busy_until = -1;
  logic [DW-1:0] lmem [DEPTH];
  logic [DW-1:0] cmem [DEPTH];
  pend_t         pq [$];
  logic          exp_rv;
  logic [DW-1:0] exp_rd;
  int            busy_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] ref_acc(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef SPAD_ACC_SAT_EN
    if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
    if (s < -(1 << (DW - 1)))    s = -(1 << (DW - 1));
`endif
    return s[DW-1:0];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      lmem[i] = '0;
      cmem[i] = '0;
    end
    pq.delete();
  endtask

  // One clock cycle: drive, check readies, update model, clock, check outputs.
  task automatic do_cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic wacc, input logic rv, input logic [AW-1:0] ra,
                          input logic clr);
    logic          busy_now;
    logic          exp_wrdy;
    logic          exp_rrdy;
    logic [DW-1:0] val;
    i_wr_valid = wv;
    i_wr_addr  = wa;
    i_wr_data  = wd;
    i_wr_accum = wacc;
    i_rd_valid = rv;
    i_rd_addr  = ra;
    i_clr      = clr;
    #1;
    busy_now = (cyc <= busy_until);
    exp_wrdy = !busy_now;
    exp_rrdy = !busy_now && !(wv && wacc);
    chk("wr_ready", 32'(o_wr_ready), 32'(exp_wrdy));
    chk("rd_ready", 32'(o_rd_ready), 32'(exp_rrdy));
    while (pq.size() > 0 && pq[0].t < cyc) begin
      cmem[pq[0].addr] = pq[0].val;
      pq.delete(0);
    end
    exp_rv = 1'b0;
    exp_rd = '0;
    if (rv && exp_rrdy) begin
      exp_rv = 1'b1;
      exp_rd = cmem[ra];
    end
    if (wv && exp_wrdy) begin
      val = wacc ? ref_acc(lmem[wa], wd) : wd;
      lmem[wa] = val;
      pq.push_back('{addr: int'(wa), val: val, t: cyc + 1});
    end
    if (clr && !busy_now) begin
      busy_until = cyc + DEPTH + 1;
      model_zero();
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("rd_valid", 32'(o_rd_valid), 32'(exp_rv));
    chk("rd_data", 32'(o_rd_data), 32'(exp_rd));
    chk("busy", 32'(o_busy), 32'(cyc <= busy_until));
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic acc);
    do_cycle(1'b1, a, d, acc, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, a, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    i_rd_valid = 1'b0;
    i_rd_addr  = '0;
    i_wr_valid = 1'b0;
    i_wr_addr  = '0;
    i_wr_data  = '0;
    i_wr_accum = 1'b0;
    i_clr      = 1'b0;
    exp_rv     = 1'b0;
    exp_rd     = '0;
    #12;
    chk("rst_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("rst_rd_ready", 32'(o_rd_ready), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_rd_data",  32'(o_rd_data),  32'd0);
    chk("rst_busy",     32'(o_busy),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_wr_ready", 32'(o_wr_ready), 32'd1);

    // Establish known contents.
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(DEPTH + 2);

    // Overwrite then read back.
    wr(9'd5, 16'h1234, 1'b0);
    idle(1);
    rd(9'd5);
    chk("t1_valid", 32'(o_rd_valid), 32'd1);
    chk("t1_data",  32'(o_rd_data),  32'h1234);

    // Back-to-back accumulates into one address.
    wr(9'd7, 16'd10, 1'b0);
    repeat (4) wr(9'd7, 16'd3, 1'b1);
    idle(2);
    rd(9'd7);
    chk("t2_data", 32'(o_rd_data), 32'd22);

    // Accumulate blocks a concurrent read; read goes through next cycle.
    do_cycle(1'b1, 9'd3, 16'd1, 1'b1, 1'b1, 9'd5, 1'b0);
    chk("t3_blocked", 32'(o_rd_valid), 32'd0);
    rd(9'd5);
    chk("t3_valid", 32'(o_rd_valid), 32'd1);
    chk("t3_data",  32'(o_rd_data),  32'h1234);

    // Overflow behaviour.
    wr(9'd9, 16'h7FF0, 1'b0);
    wr(9'd9, 16'h0020, 1'b1);
    idle(2);
    rd(9'd9);
`ifdef SPAD_ACC_SAT_EN
    chk("t4_pos_ovf", 32'(o_rd_data), 32'h7FFF);
`else
    chk("t4_pos_ovf", 32'(o_rd_data), 32'h8010);
`endif
    wr(9'd10, 16'h8000, 1'b0);
    wr(9'd10, 16'hFFFF, 1'b1);
    idle(2);
    rd(9'd10);
`ifdef SPAD_ACC_SAT_EN
    chk("t4_neg_ovf", 32'(o_rd_data), 32'h8000);
`else
    chk("t4_neg_ovf", 32'(o_rd_data), 32'h7FFF);
`endif

    // Randomized traffic on a small address window to stress forwarding.
    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom % 4) != 0, AW'($urandom % 8), DW'($urandom), 1'($urandom % 2),
               1'($urandom % 2), AW'($urandom % 8), 1'b0);
    end
    idle(2);

    // Fill, then clear with a write accepted in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      wr(AW'(i), DW'($urandom), 1'b0);
    end
    do_cycle(1'b1, 9'd20, 16'h5555, 1'b0, 1'b0, '0, 1'b1);
    busy_cnt = int'(o_busy);
    for (int i = 0; i < DEPTH + 3; i++) begin
      do_cycle(1'b0, '0, '0, 1'b0, 1'b1, AW'($urandom), 1'b0);
      busy_cnt += int'(o_busy);
    end
    chk("clr_busy_len", 32'(busy_cnt), 32'(DEPTH + 1));
    rd(9'd20);
    chk("clr_data_20", 32'(o_rd_data), 32'd0);
    rd(9'd511);
    chk("clr_data_511", 32'(o_rd_data), 32'd0);

    // Reset in the middle of a clear.
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(20);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",     32'(o_busy),     32'd0);
    chk("mid_rst_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("mid_rst_rd_ready", 32'(o_rd_ready), 32'd0);
    chk("mid_rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("mid_rst_rd_data",  32'(o_rd_data),  32'd0);
    @(posedge clk); #1;
    chk("mid_rst_busy_hold", 32'(o_busy), 32'd0);
    reset = 1'b0;
    busy_until = -1;
    pq.delete();
    exp_rv = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("post_rst_busy",     32'(o_busy),     32'd0);

    // Recover with a full clear and spot-check.
    do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle(DEPTH + 2);
    wr(9'd100, 16'hFFFE, 1'b1);
    idle(2);
    rd(9'd100);
    chk("post_rst_acc", 32'(o_rd_data), 32'h0000FFFE);
    rd(9'd300);
    chk("post_rst_zero", 32'(o_rd_data), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
